disp_bcd_encoder: RTL

Display front-end feeding the 4-digit seven-segment LED multiplexer. It accepts a binary value on a load strobe and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine, one bit per clock. It then encodes each digit to an active-low segment pattern, with optional leading-zero blanking and per-digit decimal points. The four registered patterns drive the multiplexer's LED0..LED3 inputs directly and hold steady between conversions.

---
 rtl/disp_bcd_encoder.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/disp_bcd_encoder.sv
// disp_bcd_encoder
// Converts a 14-bit binary value into four active-low seven-segment patterns
// for the LED multiplexer. The conversion is sequential double-dabble, one bit
// per clock. Each digit is then encoded, with optional leading-zero blanking
// and per-digit decimal points. The LED outputs are registered and hold steady
// between conversions.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            start a conversion (sampled only in IDLE)
//   value           binary value, captured with load
//   dp_sel          decimal-point enable per digit (bit i -> LEDi), captured with load
//   blank_lz        leading-zero blanking enable, captured with load
//   busy            high while a conversion is in progress
//   done            one-cycle pulse on the cycle the LED outputs update
//   LED0..LED3      segment patterns {a,b,c,d,e,f,g,dp}, active-low; LED0 = ones
module disp_bcd_encoder #(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = 9999
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic [3:0]       dp_sel,
    input  logic             blank_lz,
    output logic             busy,
    output logic             done,
    output logic [7:0]       LED0,
    output logic [7:0]       LED1,
    output logic [7:0]       LED2,
    output logic [7:0]       LED3
);

    localparam int SRW = 16 + WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        ENCODE = 2'd2
    } state_t;

    state_t           r_state, w_next;
    logic [SRW-1:0]   r_sr;       // {bcd[15:0], bin[WIDTH-1:0]}
    logic [3:0]       r_cnt;
    logic             r_ovf;
    logic [3:0]       r_dp;
    logic             r_blz;
    logic             r_done;
    logic [3:0][7:0]  r_led;

    logic [SRW-1:0]   w_adj;
    logic [3:0][3:0]  w_dig;
    logic [3:0][7:0]  w_led;

    function automatic logic [7:0] seg7(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'h03;
            4'd1:    s = 8'h9F;
            4'd2:    s = 8'h25;
            4'd3:    s = 8'h0D;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h49;
            4'd6:    s = 8'h41;
            4'd7:    s = 8'h1F;
            4'd8:    s = 8'h01;
            4'd9:    s = 8'h09;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (load) begin
                    w_next = (value > WIDTH'(MAXVAL)) ? ENCODE : SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == 4'(WIDTH - 1)) begin
                    w_next = ENCODE;
                end
            end
            ENCODE:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Add-3 correction of every BCD nibble >= 5, applied before each shift
    always_comb begin
        w_adj = r_sr;
        for (int i = 0; i < 4; i++) begin
            if (r_sr[WIDTH + 4*i +: 4] >= 4'd5) begin
                w_adj[WIDTH + 4*i +: 4] = r_sr[WIDTH + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Segment encoding, blanking and decimal points
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_dig[i] = r_sr[WIDTH + 4*i +: 4];
        end
        for (int i = 0; i < 4; i++) begin
            w_led[i] = r_ovf ? 8'hFD : seg7(w_dig[i]);
        end
        if (!r_ovf && r_blz) begin
            // Blank from the left only while every higher digit is also zero
            if (w_dig[3] == 4'd0)
                w_led[3] = 8'hFF;
            if (w_dig[3] == 4'd0 && w_dig[2] == 4'd0)
                w_led[2] = 8'hFF;
            if (w_dig[3] == 4'd0 && w_dig[2] == 4'd0 && w_dig[1] == 4'd0)
                w_led[1] = 8'hFF;
        end
        // Decimal point overrides every pattern, including blank and dash
        for (int i = 0; i < 4; i++) begin
            if (r_dp[i]) w_led[i][0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
            r_dp    <= '0;
            r_blz   <= 1'b0;
            r_done  <= 1'b0;
            r_led   <= {4{8'hFF}};
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_sr  <= {16'd0, value};
                        r_cnt <= '0;
                        r_ovf <= (value > WIDTH'(MAXVAL));
                        r_dp  <= dp_sel;
                        r_blz <= blank_lz;
                    end
                end
                SHIFT: begin
                    r_sr  <= w_adj << 1;
                    r_cnt <= r_cnt + 4'd1;
                end
                ENCODE: begin
                    r_led  <= w_led;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign LED0 = r_led[0];
    assign LED1 = r_led[1];
    assign LED2 = r_led[2];
    assign LED3 = r_led[3];

endmodule
